// File: rtl/clk_div_ctrl_pkg.sv
// Shared definitions for the clock-divider configuration controller:
// FSM encoding and default sizing/timing values.
package clk_div_ctrl_pkg;

   localparam int RATIO_W_DEF    = 8;
   localparam int QUIET_CYC_DEF  = 4;
   localparam int SETTLE_CYC_DEF = 2;
   localparam int DEF_RATIO_DEF  = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_LOAD   = 2'd2,
      ST_SETTLE = 2'd3
   } ctrl_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Grants are combinational; the pointer
// moves away from the winner only when the grant is actually taken.
module rr_arb2 (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_req_a,
   input  logic i_req_b,
   input  logic i_en,
   output logic o_gnt_a,
   output logic o_gnt_b
);

   logic ptr_q;   // 0 favours A, 1 favours B

   assign o_gnt_a = i_req_a & (~i_req_b | ~ptr_q);
   assign o_gnt_b = i_req_b & (~i_req_a |  ptr_q);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ptr_q <= 1'b0;
      end else if (i_en & (o_gnt_a | o_gnt_b)) begin
         ptr_q <= o_gnt_a;
      end
   end

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Sequences divide-ratio changes from two requesters into the clock divider,
// gating it around each load so the divided clock never sees a runt pulse.
//
//  state  | meaning
//  IDLE   | divider running, arbitrating requests
//  DRAIN  | divider gated, waiting QUIET_CYC cycles
//  LOAD   | new ratio applied, divider still gated
//  SETTLE | divider re-enabled, waiting SETTLE_CYC cycles before done
module clk_div_cfg_ctrl
   import clk_div_ctrl_pkg::*;
#(
   parameter int                 RATIO_W    = RATIO_W_DEF,
   parameter int                 QUIET_CYC  = QUIET_CYC_DEF,
   parameter int                 SETTLE_CYC = SETTLE_CYC_DEF,
   parameter logic [RATIO_W-1:0] DEF_RATIO  = RATIO_W'(DEF_RATIO_DEF)
) (
   input  logic               i_ref_clk,
   input  logic               i_rst,
   input  logic               i_div_en,
   input  logic               i_req_a_valid,
   input  logic [RATIO_W-1:0] i_req_a_ratio,
   output logic               o_req_a_ready,
   input  logic               i_req_b_valid,
   input  logic [RATIO_W-1:0] i_req_b_ratio,
   output logic               o_req_b_ready,
   output logic               o_div_clk_en,
   output logic [RATIO_W-1:0] o_div_ratio,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_done_id,
   output logic               o_clamp
);

   localparam int CNT_MAX = (QUIET_CYC > SETTLE_CYC) ? QUIET_CYC : SETTLE_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] QUIET_TC  = CNT_W'(QUIET_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYC - 1);

   ctrl_state_e        state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [RATIO_W-1:0] ratio_q, ratio_d;
   logic [RATIO_W-1:0] lat_ratio_q, lat_ratio_d;
   logic [RATIO_W-1:0] req_ratio, req_ratio_clamped;
   logic               lat_id_q, lat_id_d;
   logic               clk_en_q, clk_en_d;
   logic               done_q, done_d;
   logic               done_id_q, done_id_d;
   logic               clamp_q, clamp_d;
   logic               gnt_a, gnt_b;
   logic               idle, accept;

   assign idle = (state_q == ST_IDLE);

   rr_arb2 u_arb (
      .i_clk   (i_ref_clk),
      .i_rst   (i_rst),
      .i_req_a (i_req_a_valid),
      .i_req_b (i_req_b_valid),
      .i_en    (idle),
      .o_gnt_a (gnt_a),
      .o_gnt_b (gnt_b)
   );

   assign o_req_a_ready     = idle & gnt_a;
   assign o_req_b_ready     = idle & gnt_b;
   assign accept            = o_req_a_ready | o_req_b_ready;
   assign req_ratio         = gnt_b ? i_req_b_ratio : i_req_a_ratio;
   assign req_ratio_clamped = (req_ratio == '0) ? RATIO_W'(1) : req_ratio;

   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + CNT_W'(1);
      ratio_d     = ratio_q;
      lat_ratio_d = lat_ratio_q;
      lat_id_d    = lat_id_q;
      clk_en_d    = i_div_en;
      done_d      = 1'b0;
      done_id_d   = done_id_q;
      clamp_d     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (accept) begin
               clamp_d = (req_ratio == '0);
               // Same ratio: acknowledge without disturbing the divider
               if (req_ratio_clamped == ratio_q) begin
                  done_d    = 1'b1;
                  done_id_d = gnt_b;
               end else begin
                  lat_ratio_d = req_ratio_clamped;
                  lat_id_d    = gnt_b;
                  clk_en_d    = 1'b0;
                  state_d     = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            clk_en_d = 1'b0;
            if (cnt_q == QUIET_TC) begin
               ratio_d = lat_ratio_q;
               cnt_d   = '0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            cnt_d   = '0;
            state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_TC) begin
               done_d    = 1'b1;
               done_id_d = lat_id_q;
               cnt_d     = '0;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_ref_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q       <= '0;
         ratio_q     <= DEF_RATIO;
         lat_ratio_q <= DEF_RATIO;
         lat_id_q    <= 1'b0;
         clk_en_q    <= 1'b0;
         done_q      <= 1'b0;
         done_id_q   <= 1'b0;
         clamp_q     <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         ratio_q     <= ratio_d;
         lat_ratio_q <= lat_ratio_d;
         lat_id_q    <= lat_id_d;
         clk_en_q    <= clk_en_d;
         done_q      <= done_d;
         done_id_q   <= done_id_d;
         clamp_q     <= clamp_d;
      end
   end

   assign o_div_clk_en = clk_en_q;
   assign o_div_ratio  = ratio_q;
   assign o_busy       = ~idle;
   assign o_done       = done_q;
   assign o_done_id    = done_id_q;
   assign o_clamp      = clamp_q;

endmodule
